multicycle_alu: RTL and testbench

//  Parametrised, clocked successor to the combinational ALU. Single-cycle ops (add/sub/logic/compare)

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_muldiv_iter.sv | 83 ++++++++
 rtl/multicycle_alu.sv | 152 +++++++++++++++
 tb/tb_multicycle_alu.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle EX-stage ALU.
// Opcode encodings and control FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_GT   = 4'b0101;
    localparam logic [3:0] OP_MULT = 4'b0110;
    localparam logic [3:0] OP_MFHI = 4'b0111;
    localparam logic [3:0] OP_MFLO = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Ports: clk, rst_n (sync, active-low), start, is_div, a, b in; done, hi, lo out.
// done is high in the last iteration cycle; hi/lo then carry the final values
// that are written at that same edge (div: hi = quotient, lo = remainder).
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             r_busy;
    logic             r_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_rsh;
    logic [WIDTH-1:0] w_rsub;
    logic             w_ge;
    logic [WIDTH-1:0] w_nhi;
    logic [WIDTH-1:0] w_nlo;

    always_comb begin
        // Multiply: accumulator in hi, multiplier shifts out of lo.
        w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        // Divide: shifted remainder; its dropped MSB r_hi[WIDTH-1]
        // forces the subtract, and the modular difference is then exact.
        w_rsh  = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
        w_ge   = r_hi[WIDTH-1] | (w_rsh >= r_b);
        w_rsub = w_rsh - r_b;
        if (r_div) begin
            w_nhi = w_ge ? w_rsub : w_rsh;
            w_nlo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_nhi = w_madd[WIDTH:1];
            w_nlo = {w_madd[0], r_lo[WIDTH-1:1]};
        end
    end

    assign done = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign hi   = r_div ? w_nlo : w_nhi;
    assign lo   = r_div ? w_nhi : w_nlo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_div  <= is_div;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= a;
            r_b    <= b;
        end else if (r_busy) begin
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            r_cnt <= r_cnt + CW'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Clocked EX-stage ALU: single-cycle ops plus iterative MULT/DIV into HI/LO.
// Ports: clk, rst_n, in_valid/in_ready, a, b, alu_op in; out_valid, result,
// zero, div_by_zero out. Results are registered and held between completions.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_out_valid;
    logic             r_dbz;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_b_zero;
    logic             w_start;
    logic             w_gt;
    logic [WIDTH-1:0] w_res;
    logic             w_done;
    logic [WIDTH-1:0] w_it_hi;
    logic [WIDTH-1:0] w_it_lo;
    logic [WIDTH-1:0] w_done_res;

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;

    assign w_accept = in_valid & in_ready;
    assign w_is_mul = (alu_op == OP_MULT);
    assign w_is_div = (alu_op == OP_DIV);
    assign w_b_zero = (b == '0);
    // DIV by zero completes like a single-cycle op, no iteration.
    assign w_start  = w_accept & (w_is_mul | (w_is_div & ~w_b_zero));

    always_comb begin
        if (SIGNED_CMP) begin
            w_gt = $signed(a) > $signed(b);
        end else begin
            w_gt = a > b;
        end
    end

    always_comb begin
        w_res = '0;
        unique case (alu_op)
            OP_ADD:  w_res = a + b;
            OP_SUB:  w_res = a - b;
            OP_OR:   w_res = a | b;
            OP_AND:  w_res = a & b;
            OP_XOR:  w_res = a ^ b;
            OP_GT:   w_res = {{(WIDTH-1){1'b0}}, w_gt};
            OP_MFHI: w_res = r_hi;
            OP_MFLO: w_res = r_lo;
            OP_DIV:  w_res = '1;
            default: w_res = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .is_div (w_is_div),
        .a      (a),
        .b      (b),
        .done   (w_done),
        .hi     (w_it_hi),
        .lo     (w_it_lo)
    );

    assign w_done_res = (r_state == ST_DIV) ? w_it_hi : w_it_lo;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = w_is_mul ? ST_MUL : ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi        <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept && !w_start) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_zero      <= (w_res == '0);
                r_dbz       <= w_is_div;
                if (w_is_div) begin
                    r_hi <= '1;
                    r_lo <= a;
                end
            end else if (w_done) begin
                r_out_valid <= 1'b1;
                r_hi        <= w_it_hi;
                r_lo        <= w_it_lo;
                r_result    <= w_done_res;
                r_zero      <= (w_done_res == '0);
                r_dbz       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: reference model plus directed vectors.
// A second instance with signed compare shares all inputs.
module tb_multicycle_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    alu_op = 4'h0;
    logic          in_ready, out_valid, zero, div_by_zero;
    logic [W-1:0]  result;
    logic          s_in_ready, s_out_valid, s_zero, s_dbz;
    logic [W-1:0]  s_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(W), .SIGNED_CMP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid),
        .result(result), .zero(zero), .div_by_zero(div_by_zero)
    );

    multicycle_alu #(.WIDTH(W), .SIGNED_CMP(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .alu_op(alu_op), .out_valid(s_out_valid),
        .result(s_result), .zero(s_zero), .div_by_zero(s_dbz)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        logic [W-1:0] res;
        logic         dbz;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           busy_until = 0;
    bit           started = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, m_res = '0;
    logic         m_zero = 1'b1, m_dbz = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (started) begin
                logic ev;
                ev = 1'b0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    ev     = 1'b1;
                    m_res  = q[0].res;
                    m_zero = (q[0].res == '0);
                    m_dbz  = q[0].dbz;
                    void'(q.pop_front());
                end
                chk("out_valid", out_valid, ev);
                chk("in_ready", in_ready, cyc >= busy_until);
                chk("result", result, m_res);
                chk("zero", zero, m_zero);
                chk("div_by_zero", div_by_zero, m_dbz);
            end
            // Predict what the coming edge (cyc+1) does.
            if (!rst_n) begin
                started    = 1;
                q.delete();
                m_hi       = '0;
                m_lo       = '0;
                m_res      = '0;
                m_zero     = 1'b1;
                m_dbz      = 1'b0;
                busy_until = cyc + 1;
            end else if (started && in_valid && cyc >= busy_until) begin
                exp_t        e;
                logic [63:0] p;
                e.due = cyc + 1;
                e.dbz = 1'b0;
                e.res = '0;
                case (alu_op)
                    OP_ADD:  e.res = a + b;
                    OP_SUB:  e.res = a - b;
                    OP_OR:   e.res = a | b;
                    OP_AND:  e.res = a & b;
                    OP_XOR:  e.res = a ^ b;
                    OP_GT:   e.res = (a > b) ? 1 : 0;
                    OP_MFHI: e.res = m_hi;
                    OP_MFLO: e.res = m_lo;
                    OP_MULT: begin
                        p = {32'h0, a} * {32'h0, b};
                        m_hi = p[63:32];
                        m_lo = p[31:0];
                        e.res = m_lo;
                        e.due = cyc + 1 + W;
                        busy_until = cyc + 1 + W;
                    end
                    OP_DIV: begin
                        if (b == 0) begin
                            m_hi  = '1;
                            m_lo  = a;
                            e.res = '1;
                            e.dbz = 1'b1;
                        end else begin
                            m_hi  = a / b;
                            m_lo  = a % b;
                            e.res = m_hi;
                            e.due = cyc + 1 + W;
                            busy_until = cyc + 1 + W;
                        end
                    end
                    default: e.res = '0;
                endcase
                q.push_back(e);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output int lat);
        int n;
        @(posedge clk);
        #1;
        alu_op = op;
        a = x;
        b = y;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        chk("accept_wait", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid || lat >= 100) break;
            lat++;
        end
        chk("complete_wait", out_valid, 1'b1);
        r = result;
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } vec_t;

    initial begin
        logic [W-1:0] r;
        int           lat;
        int           n;
        vec_t         vt[8];

        vt[0] = '{OP_OR,  32'hF0F0_0000, 32'h0000_0F0F};
        vt[1] = '{OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0};
        vt[2] = '{OP_XOR, 32'hAAAA_5555, 32'hFFFF_FFFF};
        vt[3] = '{OP_GT,  32'h0000_0003, 32'h0000_0007};
        vt[4] = '{4'hF,   32'h1234_5678, 32'h1};
        vt[5] = '{OP_ADD, 32'h7FFF_FFFF, 32'h1};
        vt[6] = '{OP_SUB, 32'h0,         32'h1};
        vt[7] = '{OP_MFHI, 32'h0,        32'h0};

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        issue(OP_MFHI, 32'h5, 32'h6, r, lat);
        chk("rst_mfhi", r, 0);

        // Single-cycle ops.
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, r, lat);
        chk("add_wrap", r, 0);
        chk("add_zero", zero, 1);
        chk("add_lat", lat, 0);
        issue(OP_SUB, 32'd5, 32'd7, r, lat);
        chk("sub", r, 32'hFFFF_FFFE);
        issue(OP_GT, 32'hFFFF_FFFF, 32'h1, r, lat);
        chk("gt_unsigned", r, 1);
        chk("gt_signed", s_result, 0);

        // MULT.
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
        chk("mult_lat", lat, 32);
        chk("mult_lo", r, 32'h0000_0001);
        issue(OP_MFHI, 0, 0, r, lat);
        chk("mfhi", r, 32'hFFFF_FFFE);
        issue(OP_MFLO, 0, 0, r, lat);
        chk("mflo", r, 32'h0000_0001);

        // DIV.
        issue(OP_DIV, 32'd100, 32'd7, r, lat);
        chk("div_lat", lat, 32);
        chk("div_q", r, 14);
        issue(OP_MFLO, 0, 0, r, lat);
        chk("div_rem", r, 2);
        issue(OP_DIV, 32'd9, 32'd0, r, lat);
        chk("div0_res", r, 32'hFFFF_FFFF);
        chk("div0_flag", div_by_zero, 1);
        chk("div0_lat", lat, 0);
        issue(OP_ADD, 32'd1, 32'd2, r, lat);
        chk("add_after_div0", r, 3);
        chk("div0_cleared", div_by_zero, 0);
        issue(OP_MFLO, 0, 0, r, lat);
        chk("div0_lo", r, 9);

        // Back-to-back single-cycle ops, one per cycle.
        foreach (vt[i]) begin
            @(posedge clk);
            #1;
            alu_op = vt[i].op;
            a = vt[i].x;
            b = vt[i].y;
            in_valid = 1'b1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_mfhi", result, 32'hFFFF_FFFF);

        // Reset in the middle of a MULT.
        @(posedge clk);
        #1;
        alu_op = OP_MULT;
        a = 32'h1234;
        b = 32'h5678;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_ready", in_ready, 1);
        issue(OP_MFHI, 0, 0, r, lat);
        chk("abort_hi", r, 0);
        issue(OP_MFLO, 0, 0, r, lat);
        chk("abort_lo", r, 0);

        // MFLO held while busy, accepted in the MULT completion cycle.
        @(posedge clk);
        #1;
        alu_op = OP_MULT;
        a = 32'h1234_5678;
        b = 32'h10;
        in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 alu_op = OP_MFLO;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        chk("hold_wait", n, 33);
        chk("hold_mult_valid", out_valid, 1);
        chk("hold_mult_lo", result, 32'h2345_6780);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("hold_mflo_valid", out_valid, 1);
        chk("hold_mflo", result, 32'h2345_6780);
        issue(OP_MFHI, 0, 0, r, lat);
        chk("hold_mfhi", r, 32'h1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, errors %0d", errors);
        $fatal(1);
    end

endmodule
